// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
// Encodes one decoded request per accept into a 16-bit instruction word and
// queues the result in a 2-entry FIFO. Requests whose class, branch condition
// or immediate range is illegal enqueue 0x0000 flagged with out_err, and they
// bump a saturating error counter.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   request fields valid this cycle
//   in_ready   request is accepted this cycle (FIFO not full, not in reset)
//   in_class   instruction class (NOP/BRANCH/LOAD/STORE/SHIFT/ALU_RR/ALU_IMM)
//   in_cond    branch condition
//   in_op      ALU operation
//   in_rd/ra/rb destination / first source / second source register
//   in_imm     signed offset / immediate / shift amount
//   out_valid  head entry pending
//   out_ready  consumer takes the head entry
//   out_word   encoded head word
//   out_err    head entry came from an invalid request
//   err_count  saturating count of accepted invalid requests
// ---------------------------------------------------------------------------
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_class,
    input  logic [2:0]  in_cond,
    input  logic [1:0]  in_op,
    input  logic [2:0]  in_rd,
    input  logic [2:0]  in_ra,
    input  logic [2:0]  in_rb,
    input  logic [15:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_word,
    output logic        out_err,
    output logic [7:0]  err_count
);

    localparam logic [2:0] CLS_NOP     = 3'b000;
    localparam logic [2:0] CLS_BRANCH  = 3'b001;
    localparam logic [2:0] CLS_LOAD    = 3'b010;
    localparam logic [2:0] CLS_STORE   = 3'b011;
    localparam logic [2:0] CLS_SHIFT   = 3'b100;
    localparam logic [2:0] CLS_ALU_RR  = 3'b101;
    localparam logic [2:0] CLS_ALU_IMM = 3'b110;

    // Returns {err, word}; an invalid request always yields word 0x0000.
    function automatic logic [16:0] encode_req(
        input logic [2:0]  cls,
        input logic [2:0]  cond,
        input logic [1:0]  op,
        input logic [2:0]  rd,
        input logic [2:0]  ra,
        input logic [2:0]  rb,
        input logic [15:0] imm
    );
        logic signed [15:0] imm_s;
        logic [15:0]        word;
        logic               err;
        imm_s = $signed(imm);
        word  = 16'h0000;
        err   = 1'b0;
        case (cls)
            CLS_NOP: begin
                word = 16'h0000;
                err  = 1'b0;
            end
            CLS_BRANCH: begin
                // cond x11 has no meaning as a branch condition
                err  = (imm_s < -16'sd2048) || (imm_s > 16'sd2047) || (cond[1:0] == 2'b11);
                word = {1'b1, cond, imm[11:0]};
            end
            CLS_LOAD, CLS_STORE: begin
                err  = (imm_s < -16'sd64) || (imm_s > 16'sd63);
                word = {cls, rd, ra, imm[6:0]};
            end
            CLS_SHIFT: begin
                err  = (imm_s < -16'sd16) || (imm_s > 16'sd15);
                word = {5'b00000, rd, ra, imm[4:0]};
            end
            CLS_ALU_RR: begin
                err  = 1'b0;
                word = {5'b00001, op, rd, ra, rb};
            end
            CLS_ALU_IMM: begin
                err  = (imm_s < -16'sd16) || (imm_s > 16'sd15);
                word = {3'b001, op, rd, ra, imm[4:0]};
            end
            default: begin
                err  = 1'b1;
                word = 16'h0000;
            end
        endcase
        if (err) begin
            word = 16'h0000;
        end else begin
            word = word;
        end
        return {err, word};
    endfunction

    // FIFO is a shift structure: head_* is always the oldest entry.
    logic [1:0]  count_q,     count_d;
    logic [15:0] head_word_q, head_word_d;
    logic        head_err_q,  head_err_d;
    logic [15:0] tail_word_q, tail_word_d;
    logic        tail_err_q,  tail_err_d;
    logic [7:0]  err_cnt_q,   err_cnt_d;

    logic [16:0] enc_s;
    logic        push_s;
    logic        pop_s;

    assign in_ready  = ~rst & (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_word  = head_word_q;
    assign out_err   = head_err_q;
    assign err_count = err_cnt_q;

    // Handshake decode and encoding of the current request.
    always_comb begin
        enc_s  = encode_req(in_class, in_cond, in_op, in_rd, in_ra, in_rb, in_imm);
        push_s = in_valid & in_ready;
        pop_s  = out_valid & out_ready;
    end

    // FIFO next-state and saturating error counter.
    always_comb begin
        count_d     = count_q;
        head_word_d = head_word_q;
        head_err_d  = head_err_q;
        tail_word_d = tail_word_q;
        tail_err_d  = tail_err_q;
        case ({push_s, pop_s})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_word_d = enc_s[15:0];
                    head_err_d  = enc_s[16];
                end else begin
                    tail_word_d = enc_s[15:0];
                    tail_err_d  = enc_s[16];
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_word_d = tail_word_q;
                head_err_d  = tail_err_q;
                count_d     = count_q - 2'd1;
            end
            2'b11: begin
                // Only possible at occupancy 1: old head leaves, new one replaces it.
                head_word_d = enc_s[15:0];
                head_err_d  = enc_s[16];
            end
            default: begin
                count_d = count_q;
            end
        endcase
        if (push_s && enc_s[16] && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= 2'd0;
            head_word_q <= 16'h0000;
            head_err_q  <= 1'b0;
            tail_word_q <= 16'h0000;
            tail_err_q  <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            count_q     <= count_d;
            head_word_q <= head_word_d;
            head_err_q  <= head_err_d;
            tail_word_q <= tail_word_d;
            tail_err_q  <= tail_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
// Directed scenarios followed by randomized traffic, checked each cycle
// against a queue-based reference model of the encoder and its FIFO.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_class;
    logic [2:0]  in_cond;
    logic [1:0]  in_op;
    logic [2:0]  in_rd;
    logic [2:0]  in_ra;
    logic [2:0]  in_rb;
    logic [15:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_word;
    logic        out_err;
    logic [7:0]  err_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [16:0] mq[$];
    int          m_cnt = 0;

    instr_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_class  (in_class),
        .in_cond   (in_cond),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_ra     (in_ra),
        .in_rb     (in_rb),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_err   (out_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference encoding built from field weights with plain arithmetic.
    function automatic void ref_encode(input logic [2:0] cls, input logic [2:0] cond,
                                       input logic [1:0] op, input logic [2:0] rd,
                                       input logic [2:0] ra, input logic [2:0] rb,
                                       input logic [15:0] imm,
                                       output logic [15:0] w, output logic e);
        int v;
        int x;
        v = int'($signed(imm));
        x = 0;
        e = 1'b0;
        case (int'(cls))
            0: x = 0;
            1: begin
                e = (v < -2048) || (v > 2047) || (cond == 3'd3) || (cond == 3'd7);
                x = 32768 + int'(cond) * 4096 + (v & 4095);
            end
            2, 3: begin
                e = (v < -64) || (v > 63);
                x = int'(cls) * 8192 + int'(rd) * 1024 + int'(ra) * 128 + (v & 127);
            end
            4: begin
                e = (v < -16) || (v > 15);
                x = int'(rd) * 256 + int'(ra) * 32 + (v & 31);
            end
            5: x = 2048 + int'(op) * 512 + int'(rd) * 64 + int'(ra) * 8 + int'(rb);
            6: begin
                e = (v < -16) || (v > 15);
                x = 8192 + int'(op) * 2048 + int'(rd) * 256 + int'(ra) * 32 + (v & 31);
            end
            default: e = 1'b1;
        endcase
        if (e) x = 0;
        w = 16'(x);
    endfunction

    task automatic set_req(input int cls, input int cond, input int op, input int rd,
                           input int ra, input int rb, input int imm);
        in_valid = 1'b1;
        in_class = 3'(cls);
        in_cond  = 3'(cond);
        in_op    = 2'(op);
        in_rd    = 3'(rd);
        in_ra    = 3'(ra);
        in_rb    = 3'(rb);
        in_imm   = 16'(imm);
    endtask

    // One clock: check outputs at the falling edge, then advance the model.
    task automatic step();
        logic [15:0] w;
        logic        e;
        bit          push;
        bit          pop;
        @(negedge clk);
        check_eq("in_ready", {15'd0, in_ready}, (mq.size() < 2) ? 16'd1 : 16'd0);
        check_eq("out_valid", {15'd0, out_valid}, (mq.size() > 0) ? 16'd1 : 16'd0);
        if (mq.size() > 0) begin
            check_eq("out_word", out_word, mq[0][15:0]);
            check_eq("out_err", {15'd0, out_err}, {15'd0, mq[0][16]});
        end
        check_eq("err_count", {8'd0, err_count}, 16'(m_cnt));
        push = in_valid && (mq.size() < 2);
        pop  = (mq.size() > 0) && out_ready;
        ref_encode(in_class, in_cond, in_op, in_rd, in_ra, in_rb, in_imm, w, e);
        @(posedge clk);
        #1;
        if (pop) void'(mq.pop_front());
        if (push) begin
            mq.push_back({e, w});
            if (e && m_cnt < 255) m_cnt++;
        end
    endtask

    int bounds[12] = '{-2049, -2048, 2047, 2048, -65, -64, 63, 64, -17, -16, 15, 16};

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0;
        in_class = 3'd0; in_cond = 3'd0; in_op = 2'd0;
        in_rd = 3'd0; in_ra = 3'd0; in_rb = 3'd0; in_imm = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", {15'd0, in_ready}, 16'd0);
        check_eq("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check_eq("rst_out_word", out_word, 16'h0000);
        check_eq("rst_out_err", {15'd0, out_err}, 16'd0);
        check_eq("rst_err_count", {8'd0, err_count}, 16'd0);
        rst = 1'b0;

        // LOAD rd=3 ra=5 imm=-1
        out_ready = 1'b1;
        set_req(2, 0, 0, 3, 5, 0, -1);
        step();
        in_valid = 1'b0;
        check_eq("load_valid", {15'd0, out_valid}, 16'd1);
        check_eq("load_word", out_word, 16'h4EFF);
        check_eq("load_err", {15'd0, out_err}, 16'd0);
        step();

        // BRANCH then ALU_RR; occupancy 1 with simultaneous accept and pop
        out_ready = 1'b0;
        set_req(1, 6, 3, 7, 7, 7, 5);
        step();
        check_eq("branch_word", out_word, 16'hE005);
        out_ready = 1'b1;
        set_req(5, 7, 2, 1, 2, 3, 12345);
        step();
        in_valid = 1'b0;
        check_eq("aluRR_word", out_word, 16'h0C53);
        check_eq("aluRR_valid", {15'd0, out_valid}, 16'd1);
        step();
        step();

        // Two invalid requests
        out_ready = 1'b0;
        set_req(6, 0, 1, 1, 1, 1, 16);
        step();
        set_req(1, 3, 0, 0, 0, 0, 0);
        step();
        in_valid = 1'b0;
        check_eq("err2_count", {8'd0, err_count}, 16'd2);
        check_eq("err2_word", out_word, 16'h0000);
        check_eq("err2_flag", {15'd0, out_err}, 16'd1);
        out_ready = 1'b1;
        repeat (3) step();

        // Three back-to-back requests into a stalled consumer
        out_ready = 1'b0;
        set_req(4, 0, 0, 1, 2, 0, 3);
        step();
        set_req(3, 0, 0, 4, 5, 0, -64);
        step();
        set_req(6, 0, 3, 6, 7, 0, -16);
        repeat (3) step();
        check_eq("full_in_ready", {15'd0, in_ready}, 16'd0);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();

        // 300 invalid requests saturate the counter
        set_req(7, 0, 0, 0, 0, 0, 0);
        repeat (300) step();
        in_valid = 1'b0;
        step();
        check_eq("sat_count", {8'd0, err_count}, 16'd255);

        // Reset with two entries pending
        out_ready = 1'b0;
        set_req(2, 0, 0, 1, 1, 0, 1);
        repeat (2) step();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", {15'd0, out_valid}, 16'd0);
        check_eq("mid_rst_count", {8'd0, err_count}, 16'd0);
        check_eq("mid_rst_ready", {15'd0, in_ready}, 16'd0);
        mq.delete();
        m_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        set_req(5, 0, 1, 2, 3, 4, 0);
        step();
        in_valid = 1'b0;
        check_eq("post_rst_word", out_word, 16'h0A9C);
        step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int sel;
            int imm;
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: imm = int'($urandom_range(0, 40)) - 20;
                1: imm = bounds[$urandom_range(0, 11)];
                2: imm = int'($urandom_range(0, 65535)) - 32768;
                default: imm = int'($urandom_range(0, 140)) - 70;
            endcase
            set_req(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), imm);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have exactly one clock and one reset: clock port clk, reset port rst; rst is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  request fields valid this cycle.
REQ-005 in_ready  output  1  block accepts a request this cycle.
REQ-006 in_class  input  3  000 NOP, 001 BRANCH, 010 LOAD, 011 STORE, 100 SHIFT, 101 ALU_RR, 110 ALU_IMM, 111 illegal.
REQ-007 in_cond  input  3  branch condition: 000 always, 001 LT, 010 GT, 100 Z, 101 LE, 110 GE.
REQ-008 in_op  input  2  ALU operation for ALU_RR/ALU_IMM.
REQ-009 in_rd, in_ra, in_rb  input  3 each  destination, first source, second source register.
REQ-010 in_imm  input  16  signed two's-complement offset/immediate/shift amount.
REQ-011 out_valid  output  1  out_word/out_err hold a pending entry.
REQ-012 out_ready  input  1  consumer takes the head entry when out_valid=1.
REQ-013 out_word  output  16  encoded instruction.
REQ-014 out_err  output  1  head entry came from an invalid request.
REQ-015 err_count  output  8  saturating count of invalid requests accepted.

Function
REQ-016 Accept occurs on a rising edge with in_valid=1 and in_ready=1; pop occurs on a rising edge with out_valid=1 and out_ready=1.
REQ-017 Encoded words SHALL pass through a 2-entry FIFO; in_ready=1 iff occupancy<2, independent of out_ready (no pass-through when full).
REQ-018 out_valid=1 iff occupancy>0; latency one cycle: a request accepted at edge N into an empty FIFO appears at out_word after edge N.
REQ-019 Accept and pop on the same edge SHALL leave occupancy unchanged and preserve FIFO order; the popped entry is never the one just accepted.
REQ-020 out_word/out_err SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 BRANCH: [15]=1, [14:12]=in_cond, [11:0]=in_imm[11:0]; legal range -2048..2047; in_cond 011 or 111 invalid.
REQ-022 LOAD: [15:13]=010; STORE: [15:13]=011; both [12:10]=in_rd, [9:7]=in_ra, [6:0]=in_imm[6:0], range -64..63.
REQ-023 SHIFT: [15:11]=00000, [10:8]=in_rd, [7:5]=in_ra, [4:0]=in_imm[4:0], range -16..15.
REQ-024 ALU_RR: [15:11]=00001, [10:9]=in_op, [8:6]=in_rd, [5:3]=in_ra, [2:0]=in_rb; in_imm ignored.
REQ-025 ALU_IMM: [15:13]=001, [12:11]=in_op, [10:8]=in_rd, [7:5]=in_ra, [4:0]=in_imm[4:0], range -16..15.
REQ-026 NOP: word 0x0000, never an error.
REQ-027 Out-of-range in_imm (full 16-bit signed compare), illegal class, or illegal cond SHALL enqueue 0x0000 with out_err=1 and increment err_count on the accept edge.
REQ-028 err_count SHALL saturate at 255; requests not accepted (in_ready=0) SHALL not count.
REQ-029 Unused fields for a class SHALL not affect out_word.

Reset
REQ-030 While rst=1: occupancy 0, out_valid=0, in_ready=0, out_word=0x0000, out_err=0, err_count=0.
REQ-031 rst asserted mid-operation SHALL discard all FIFO entries immediately; in_ready=1 on the first cycle after rst deasserts.

Verification
REQ-032 LOAD rd=3 ra=5 imm=-1, out_ready=1 -> out_word=0x4EFF, out_err=0, out_valid one cycle after accept.
REQ-033 BRANCH cond=110 imm=5 -> 0xE005; ALU_RR op=10 rd=1 ra=2 rb=3 -> 0x0C53.
REQ-034 ALU_IMM imm=16, then BRANCH cond=011 -> two entries 0x0000 with out_err=1, err_count=2.
REQ-035 out_ready=0, three back-to-back requests -> in_ready=0 after two accepts, third held; release out_ready -> order preserved.
REQ-036 Occupancy 1, simultaneous accept and pop -> occupancy stays 1, correct ordering; 300 invalid requests -> err_count=255.
REQ-037 rst pulse with 2 entries pending -> out_valid=0 immediately, err_count=0, next request encodes normally.
